rle_bit_tx: RTL
===============

Name: rle_bit_tx

Overview:
- Run-length serial bit transmitter: accepts (bit value, run length) commands over a valid/ready handshake and emits the corresponding serial bit stream, one bit per enable strobe.
- Transmit-side counterpart to the serial pattern detectors (FSM_bin) in the lab designs. Drives their `in` input with deterministic runs of 0s and 1s.
- Provides a one-entry command buffer so consecutive runs are emitted without gaps.

Parameters:
- LEN_W, 4: width of the run-length field. Maximum run is 2^LEN_W-1 bits.
- IDLE_BIT, 0: value driven on `out` when no bit is being emitted.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- en, input, 1: bit strobe; at most one bit is emitted per edge with en=1.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: command slot can accept.
- cmd_bit, input, 1: bit value of the run.
- cmd_len, input, LEN_W: number of bits in the run.
- out, output, 1: serial bit, registered.
- out_valid, output, 1: registered; high for exactly one cycle per emitted bit.
- run_done, output, 1: registered one-cycle pulse, coincident with the last bit of each run.
- busy, output, 1: a run is active or a command is pending.

Behaviour:
- State:
  - active run: act_bit, act_rem[LEN_W-1:0], where act_rem is the number of bits still to emit after the current one.
  - pending slot: pend_full, pend_bit, pend_len.
  - running flag.
- Reset (async, reset=0), effective immediately:
  - running=0, act_rem=0, pend_full=0.
  - out=IDLE_BIT, out_valid=0, run_done=0, busy=0.
  - A run in progress is discarded: no further bits, no run_done.
- load_now = en & (~running | act_rem==0) & pend_full. Combinational.
- cmd_ready = ~pend_full | load_now. Combinational; reads 1 during reset.
- Accept: on an edge with cmd_valid & cmd_ready, the command is written into the pending slot.
  - cmd_len=0: accepted and dropped. The slot stays as it was, no bits, no run_done.
- Per edge with en=1, in priority order:
  1. running & act_rem>0: out<=act_bit, out_valid<=1, act_rem<=act_rem-1. run_done<=1 iff act_rem==1.
  2. Else if pend_full: load the pending command. out<=pend_bit, out_valid<=1, act_bit<=pend_bit, act_rem<=pend_len-1, running<=1, pend_full<=0 unless a new command is accepted on the same edge. run_done<=1 iff pend_len==1.
  3. Else: running<=0, out<=IDLE_BIT, out_valid<=0, run_done<=0.
- Edge with en=0:
  - out_valid<=0, run_done<=0.
  - out, act_rem and the pending slot hold.
  - Accepts into an empty slot are still allowed.
- Latency:
  - A command accepted at edge N produces its first bit at the first en edge strictly after N. There is no same-edge bypass.
  - Back-to-back runs are gapless: the next run's first bit follows the previous run's last bit on the next en edge.
- Throughput: with en held at 1, len=1 commands sustain one bit per cycle, because cmd_ready stays high via load_now.
- busy = running | pend_full.
- Boundaries:
  - The maximum cmd_len emits exactly 2^LEN_W-1 bits.
  - The counter never wraps: act_rem stops at 0.
- No combinational path from cmd_* to out, out_valid or run_done.

Test Plan:
1. Release reset, en=1 constant, send (bit=1, len=4).
   - Expect out_valid high for 4 consecutive cycles with out=1, starting the edge after acceptance.
   - Expect run_done on the 4th bit.
   - Expect out=0, out_valid=0 and busy=0 afterwards.
2. Send (0,3) then (1,2) back to back with en=1.
   - Expect out sequence 0,0,0,1,1 on 5 consecutive cycles with no gap.
   - Expect run_done on bits 3 and 5.
3. Send (1,3) with en pattern 1,0,0,1,0,1.
   - Expect out_valid high only on the 3 en edges.
   - Expect run_done with the 3rd bit.
   - Expect out to hold 1 through the en=0 cycles.
4. Send (0,0) then (1,1).
   - Expect both accepted; exactly one bit (out=1) and one run_done pulse.
5. Hold cmd_valid with (1,15), (0,15), (1,15) while en=1.
   - Expect cmd_ready to drop while the slot is full and rise on the load edges.
   - Expect 45 consecutive bits in runs of 15.
   - Expect busy to fall exactly one cycle after the last bit.
6. Run (0,5) and assert reset asynchronously after 2 bits.
   - Expect out=0, out_valid=0, busy=0 and cmd_ready=1 immediately, not at the next edge.
   - Expect no run_done.
   - After release, (1,1) emits normally.

Source files
------------

// File: rtl/rle_bit_tx.sv
// Run-length serial bit transmitter. It takes (bit, length) commands through a
// one-entry pending slot and emits the runs back to back, one bit per enable strobe.
module rle_bit_tx #(
    parameter int   LEN_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             out,
    output logic             out_valid,
    output logic             run_done,
    output logic             busy
);

    logic             running_q, running_d;
    logic             act_bit_q, act_bit_d;
    logic [LEN_W-1:0] act_rem_q, act_rem_d;
    logic             pend_full_q, pend_full_d;
    logic             pend_bit_q, pend_bit_d;
    logic [LEN_W-1:0] pend_len_q, pend_len_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             run_done_q, run_done_d;

    logic rem_zero;
    logic load_now;
    logic accept;

    // The slot frees up on the same edge that loads it, so ready looks ahead at that load.
    assign rem_zero  = (act_rem_q == '0);
    assign load_now  = en & (~running_q | rem_zero) & pend_full_q;
    assign cmd_ready = ~pend_full_q | load_now;
    assign accept    = cmd_valid & cmd_ready & (cmd_len != '0);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through this block infers a latch.
        running_d   = running_q;
        act_bit_d   = act_bit_q;
        act_rem_d   = act_rem_q;
        pend_full_d = pend_full_q;
        pend_bit_d  = pend_bit_q;
        pend_len_d  = pend_len_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        run_done_d  = 1'b0;

        if (en) begin
            if (running_q && !rem_zero) begin
                out_d       = act_bit_q;
                out_valid_d = 1'b1;
                act_rem_d   = act_rem_q - LEN_W'(1);
                run_done_d  = (act_rem_q == LEN_W'(1));
            end else if (pend_full_q) begin
                out_d       = pend_bit_q;
                out_valid_d = 1'b1;
                act_bit_d   = pend_bit_q;
                act_rem_d   = pend_len_q - LEN_W'(1);
                running_d   = 1'b1;
                pend_full_d = 1'b0;
                run_done_d  = (pend_len_q == LEN_W'(1));
            end else begin
                running_d = 1'b0;
                out_d     = IDLE_BIT;
            end
        end

        // A zero-length command is taken off the bus but leaves the slot untouched.
        if (accept) begin
            pend_full_d = 1'b1;
            pend_bit_d  = cmd_bit;
            pend_len_d  = cmd_len;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running_q   <= 1'b0;
            act_bit_q   <= 1'b0;
            act_rem_q   <= '0;
            pend_full_q <= 1'b0;
            pend_bit_q  <= 1'b0;
            pend_len_q  <= '0;
            out_q       <= IDLE_BIT;
            out_valid_q <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            running_q   <= running_d;
            act_bit_q   <= act_bit_d;
            act_rem_q   <= act_rem_d;
            pend_full_q <= pend_full_d;
            pend_bit_q  <= pend_bit_d;
            pend_len_q  <= pend_len_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            run_done_q  <= run_done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign run_done  = run_done_q;
    assign busy      = running_q | pend_full_q;

endmodule
